// File: rtl/tree_sort_pkg.sv
// Shared constants, helpers and macros for the min-priority tree sorter.
// Priority sentinel reported when no window survives: all-ones of width w.
`define TS_PRI_SENTINEL(w) {(w){1'b1}}
// Window i of a packed per-window bus whose elements are w bits wide.
`define TS_WIN(vec, i, w) vec[(i)*(w) +: (w)]

package tree_sort_pkg;

   localparam int unsigned NWIN_MAX = 64;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/tree_sorter_min_pipe_if.sv
// Candidate-set input and winner output bundle of tree_sorter_min_pipe.
interface tree_sorter_min_pipe_if #(
   parameter int unsigned NWIN  = 8,
   parameter int unsigned PRI_W = 10,
   parameter int unsigned DAT_W = 10,
   parameter int unsigned TAG_W = 12,
   parameter int unsigned CNT_W = 16
);
   localparam int unsigned IDX_W = tree_sort_pkg::clog2(NWIN);

   logic                    in_valid;
   logic [NWIN-1:0]         in_mask;
   logic [NWIN*PRI_W-1:0]   in_pri;
   logic [NWIN*DAT_W-1:0]   in_dat;
   logic [TAG_W-1:0]        in_tag;
   logic [PRI_W-1:0]        pri_max;
   logic                    cnt_clear;
   logic                    out_valid;
   logic                    out_found;
   logic [IDX_W-1:0]        win_best;
   logic [PRI_W-1:0]        pri_best;
   logic [DAT_W-1:0]        dat_best;
   logic [TAG_W-1:0]        out_tag;
   logic [CNT_W-1:0]        found_cnt;

   modport master (
      output in_valid, in_mask, in_pri, in_dat, in_tag, pri_max, cnt_clear,
      input  out_valid, out_found, win_best, pri_best, dat_best, out_tag, found_cnt
   );

   modport slave (
      input  in_valid, in_mask, in_pri, in_dat, in_tag, pri_max, cnt_clear,
      output out_valid, out_found, win_best, pri_best, dat_best, out_tag, found_cnt
   );

endinterface

// File: rtl/tree_sort_cell2.sv
// Registered 2:1 min-priority compare cell; ties and the empty case keep operand A.
module tree_sort_cell2 #(
   parameter int unsigned PRI_W   = 10,
   parameter int unsigned DAT_W   = 10,
   parameter int unsigned IDX_W   = 3,
   parameter int unsigned SEL_BIT = 0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             a_ok_i,
   input  logic [PRI_W-1:0] a_pri_i,
   input  logic [DAT_W-1:0] a_dat_i,
   input  logic [IDX_W-1:0] a_idx_i,
   input  logic             b_ok_i,
   input  logic [PRI_W-1:0] b_pri_i,
   input  logic [DAT_W-1:0] b_dat_i,
   input  logic [IDX_W-1:0] b_idx_i,
   output logic             y_ok_o,
   output logic [PRI_W-1:0] y_pri_o,
   output logic [DAT_W-1:0] y_dat_o,
   output logic [IDX_W-1:0] y_idx_o
);

   logic             take_b;
   logic             y_ok_d;
   logic [PRI_W-1:0] y_pri_d;
   logic [DAT_W-1:0] y_dat_d;
   logic [IDX_W-1:0] y_idx_d;

   always_comb begin
      take_b  = b_ok_i & (~a_ok_i | (b_pri_i < a_pri_i));
      y_ok_d  = a_ok_i | b_ok_i;
      y_pri_d = take_b ? b_pri_i : a_pri_i;
      y_dat_d = take_b ? b_dat_i : a_dat_i;
      y_idx_d = take_b ? b_idx_i : a_idx_i;
      // This level owns one index bit; deeper levels own the bits below it.
      y_idx_d[SEL_BIT] = take_b;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         y_ok_o  <= 1'b0;
         y_pri_o <= '0;
         y_dat_o <= '0;
         y_idx_o <= '0;
      end else begin
         y_ok_o  <= y_ok_d;
         y_pri_o <= y_pri_d;
         y_dat_o <= y_dat_d;
         y_idx_o <= y_idx_d;
      end
   end

endmodule

// File: rtl/tree_sorter_min_pipe.sv
// Pipelined minimum-priority tree encoder: qualifier stage, log2(NWIN) compare levels,
// tag/valid delay line and a saturating found counter.
module tree_sorter_min_pipe
   import tree_sort_pkg::*;
#(
   parameter int unsigned NWIN  = 8,
   parameter int unsigned PRI_W = 10,
   parameter int unsigned DAT_W = 10,
   parameter int unsigned TAG_W = 12,
   parameter int unsigned CNT_W = 16
) (
   input logic                   clock,
   input logic                   reset_n,
   tree_sorter_min_pipe_if.slave bus
);

   localparam int unsigned LVLS  = clog2(NWIN);
   localparam int unsigned LAT   = LVLS + 1;
   localparam int unsigned IDX_W = LVLS;
   localparam int unsigned ROOT  = NWIN - 2;

   if (NWIN < 2 || NWIN > NWIN_MAX || (32'd1 << LVLS) != NWIN) begin : g_bad_nwin
      $error("NWIN must be a power of two in 2..64");
   end

   logic [NWIN-1:0]  s0_ok_q;
   logic [PRI_W-1:0] s0_pri_q [NWIN];
   logic [DAT_W-1:0] s0_dat_q [NWIN];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s0_ok_q <= '0;
         for (int i = 0; i < NWIN; i++) begin
            s0_pri_q[i] <= '0;
            s0_dat_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NWIN; i++) begin
            s0_ok_q[i]  <= bus.in_valid & bus.in_mask[i]
                           & (`TS_WIN(bus.in_pri, i, PRI_W) <= bus.pri_max);
            s0_pri_q[i] <= `TS_WIN(bus.in_pri, i, PRI_W);
            s0_dat_q[i] <= `TS_WIN(bus.in_dat, i, DAT_W);
         end
      end
   end

   // Compare nodes stored level by level: level l starts at NWIN - 2*(NWIN >> l).
   logic             nd_ok  [NWIN-1];
   logic [PRI_W-1:0] nd_pri [NWIN-1];
   logic [DAT_W-1:0] nd_dat [NWIN-1];
   logic [IDX_W-1:0] nd_idx [NWIN-1];

   for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
      localparam int unsigned NCELL   = NWIN >> l;
      localparam int unsigned OFF_OUT = NWIN - 2 * (NWIN >> l);

      for (genvar c = 0; c < NCELL; c++) begin : g_cell
         logic             a_ok, b_ok;
         logic [PRI_W-1:0] a_pri, b_pri;
         logic [DAT_W-1:0] a_dat, b_dat;
         logic [IDX_W-1:0] a_idx, b_idx;

         if (l == 1) begin : g_leaf
            assign a_ok  = s0_ok_q[2*c];
            assign b_ok  = s0_ok_q[2*c+1];
            assign a_pri = s0_pri_q[2*c];
            assign b_pri = s0_pri_q[2*c+1];
            assign a_dat = s0_dat_q[2*c];
            assign b_dat = s0_dat_q[2*c+1];
            assign a_idx = '0;
            assign b_idx = '0;
         end else begin : g_inner
            localparam int unsigned OFF_IN = NWIN - 2 * (NWIN >> (l - 1));
            assign a_ok  = nd_ok[OFF_IN + 2*c];
            assign b_ok  = nd_ok[OFF_IN + 2*c + 1];
            assign a_pri = nd_pri[OFF_IN + 2*c];
            assign b_pri = nd_pri[OFF_IN + 2*c + 1];
            assign a_dat = nd_dat[OFF_IN + 2*c];
            assign b_dat = nd_dat[OFF_IN + 2*c + 1];
            assign a_idx = nd_idx[OFF_IN + 2*c];
            assign b_idx = nd_idx[OFF_IN + 2*c + 1];
         end

         tree_sort_cell2 #(
            .PRI_W  (PRI_W),
            .DAT_W  (DAT_W),
            .IDX_W  (IDX_W),
            .SEL_BIT(l - 1)
         ) u_cell (
            .clk_i  (clock),
            .rst_ni (reset_n),
            .a_ok_i (a_ok),
            .a_pri_i(a_pri),
            .a_dat_i(a_dat),
            .a_idx_i(a_idx),
            .b_ok_i (b_ok),
            .b_pri_i(b_pri),
            .b_dat_i(b_dat),
            .b_idx_i(b_idx),
            .y_ok_o (nd_ok[OFF_OUT + c]),
            .y_pri_o(nd_pri[OFF_OUT + c]),
            .y_dat_o(nd_dat[OFF_OUT + c]),
            .y_idx_o(nd_idx[OFF_OUT + c])
         );
      end
   end

   logic [LAT-1:0]   vld_q;
   logic [TAG_W-1:0] tag_q [LAT];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         vld_q <= '0;
         for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
      end else begin
         vld_q    <= {vld_q[LAT-2:0], bus.in_valid};
         tag_q[0] <= bus.in_tag;
         for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   logic             found;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      found = vld_q[LAT-1] & nd_ok[ROOT];
      cnt_d = cnt_q;
      if (bus.cnt_clear) begin
         cnt_d = '0;
      end else if (found && cnt_q != '1) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign bus.out_valid = vld_q[LAT-1];
   assign bus.out_found = found;
   assign bus.out_tag   = tag_q[LAT-1];
   assign bus.win_best  = found ? nd_idx[ROOT] : '0;
   assign bus.pri_best  = found ? nd_pri[ROOT]
                                : (vld_q[LAT-1] ? `TS_PRI_SENTINEL(PRI_W) : '0);
   assign bus.dat_best  = found ? nd_dat[ROOT] : '0;
   assign bus.found_cnt = cnt_q;

endmodule
